// File: rtl/dcm_rst_ctrl.sv
// Reset sequencer / lock supervisor for the board DCM.
// Pulses the DCM reset, waits for lock within a timeout (with retries),
// demands a stable lock window before releasing sys_rst, and re-runs the
// whole sequence on lock loss. Runs on the free-running pad clock.
module dcm_rst_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dcm_locked,
  input  logic       soft_rst_req,
  output logic       dcm_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // terminal counts: cnt is 0 on the first cycle in a state
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_DCM_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [7:0]       relock_d;
  logic [1:0]       lk_pipe;
  logic             lk;

  assign lk = lk_pipe[1];

  // two-flop synchronizer for the asynchronous LOCKED pin
  always_ff @(posedge clk) begin
    if (rst) lk_pipe <= '0;
    else     lk_pipe <= {lk_pipe[0], dcm_locked};
  end

  // state, counters and outputs; outputs decode the next state so they
  // move on the same edge as the state itself
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DCM_RST;
      cnt_q      <= '0;
      retry_q    <= '0;
      relock_cnt <= '0;
      dcm_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      relock_cnt <= relock_d;
      dcm_rst    <= (state_d == ST_DCM_RST) || (state_d == ST_FAIL);
      sys_rst    <= (state_d != ST_RUN);
      ready      <= (state_d == ST_RUN);
      fail       <= (state_d == ST_FAIL);
    end
  end

  // next-state logic; lock loss takes priority over soft reset in RUN,
  // and a lock arriving on the timeout cycle wins over the timeout
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    relock_d = relock_cnt;
    case (state_q)
      ST_DCM_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RTY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_DCM_RST;
          end
        end
      end
      ST_STABLE: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          if (relock_cnt != 8'hFF) relock_d = relock_cnt + 8'd1;
          state_d = ST_DCM_RST;
        end else if (soft_rst_req) begin
          state_d = ST_STABLE;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_DCM_RST;
      end
    endcase
    // one shared counter, restarted on every state entry
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: doc/dcm_rst_ctrl.md
# dcm_rst_ctrl

Reset sequencer and lock supervisor for the board's DCM clock generator. It runs on the free-running input clock. It pulses the DCM reset, waits for `locked` within a timeout, and requires lock to be held stable before releasing the synchronous system reset. It also re-runs the whole sequence when lock is lost during operation. It sits between the clock generator and every downstream reset consumer (CPU core, memory controllers, display).

## Interface
- `RST_CYCLES`, 4: cycles `dcm_rst` is held high per attempt; must be ≥ 3 to meet the DCM minimum.
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before an attempt is abandoned.
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release; also the soft-reset length.
- `MAX_RETRY`, 3: extra DCM reset attempts after the first before declaring failure.
- `CNT_W`, 17: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) − 1.

Ports (reset is synchronous, active-high; one clock):
- `clk` in 1: free-running input clock (pad clock, pre-DCM).
- `rst` in 1: synchronous active-high reset.
- `dcm_locked` in 1: DCM LOCKED, asynchronous to `clk`; synchronized internally.
- `soft_rst_req` in 1: single-cycle request to pulse `sys_rst` without touching the DCM.
- `dcm_rst` out 1: drives the DCM RST pin.
- `sys_rst` out 1: synchronous active-high reset to the system.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `relock_cnt` out 8: number of RUN→lock-loss events, saturating at 255.

## Operation
- `dcm_locked` passes through a 2-flop synchronizer to `lk`. All decisions use `lk`.
- FSM states: DCM_RST, WAIT_LOCK, STABLE, RUN, FAIL.
- One counter `cnt` is cleared on every state entry. It increments once per cycle spent in a state.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Output values by state:
  - `dcm_rst` = 1 in DCM_RST and FAIL.
  - `sys_rst` = 0 only in RUN.
  - `ready` = (state == RUN).
  - `fail` = (state == FAIL).
- On `rst`: state DCM_RST, cnt = 0, retry = 0, relock_cnt = 0, synchronizer = 0, dcm_rst = 1, sys_rst = 1, ready = 0, fail = 0.
- `rst` wins over every other event in any state.
- **DCM_RST:** when cnt == RST_CYCLES−1, go to WAIT_LOCK. Occupancy is exactly RST_CYCLES cycles.
- **WAIT_LOCK:**
  - If `lk` = 1, go to STABLE.
  - Else, when cnt == LOCK_TIMEOUT−1: if retry == MAX_RETRY, go to FAIL; otherwise retry++ and go to DCM_RST.
  - `lk` rising on the timeout cycle: lock wins.
- **STABLE:**
  - If `lk` = 0, go to WAIT_LOCK; the timeout restarts and retry is unchanged.
  - Else, when cnt == STABLE_CYCLES−1, go to RUN and clear retry.
- **RUN:**
  - If `lk` = 0, relock_cnt++ (saturating) and go to DCM_RST.
  - Else, if `soft_rst_req` = 1, go to STABLE; the DCM is untouched.
  - Both on the same cycle: lock loss wins and relock_cnt increments.
- **FAIL:** absorbing; exited only by `rst`. `dcm_rst` is held high to keep the DCM quiescent.
- `soft_rst_req` is ignored outside RUN.

## Timing
- Synchronizer latency: a `dcm_locked` change sampled at edge k appears on `lk` after edge k+1. The FSM acts on it at edge k+2.
- Bring-up latency: after the first rising edge with `rst` low, `dcm_rst` stays high RST_CYCLES cycles.
- Release: if `dcm_locked` rises and is sampled at edge k, `sys_rst` falls at edge k+2+STABLE_CYCLES.
- Lock loss in RUN: `dcm_locked` falling, sampled at edge k, gives `sys_rst` = 1, `ready` = 0 and `dcm_rst` = 1 at edge k+2.
- Timeout attempt: each failed attempt costs RST_CYCLES + LOCK_TIMEOUT cycles. FAIL is entered (MAX_RETRY+1)·(RST_CYCLES+LOCK_TIMEOUT) cycles after reset release.
- Soft reset: `sys_rst` is high for exactly STABLE_CYCLES cycles, starting the edge after the request is sampled, provided lock holds.
- No combinational path from any input to any output.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2.
- **Normal bring-up:** release rst at edge 0; `dcm_locked` rises 10 cycles after `dcm_rst` falls.
  - `dcm_rst` is high for edges 0–3.
  - `sys_rst` falls 2+8 edges after lock is sampled.
  - `ready` = 1 and `fail` = 0 in RUN.
- **Lock never asserts:** exactly 3 `dcm_rst` pulses of 4 cycles each.
  - `fail` = 1 and `dcm_rst` = 1 at cycle 108.
  - `sys_rst` stays 1 throughout.
- **One-cycle lock dropout during STABLE (cnt = 5):** FSM returns to WAIT_LOCK with no extra `dcm_rst` pulse.
  - `sys_rst` falls 8 cycles after lock is re-sampled stable plus 2.
- **Lock drop in RUN:** `sys_rst` = 1 at edge k+2 and `relock_cnt` goes 0→1.
  - A 4-cycle `dcm_rst` pulse follows, then normal re-release.
  - Repeated 300 times, `relock_cnt` saturates at 255.
- **`soft_rst_req` pulse in RUN:** `sys_rst` high 8 cycles, `dcm_rst` stays 0, `relock_cnt` unchanged.
  - Same request on the same cycle as a lock drop takes the lock-loss path.
- **`rst` asserted mid-WAIT_LOCK (cnt = 20, retry = 1):** the next cycle shows DCM_RST behaviour.
  - retry = 0, and the full timeout budget is restored (3 attempts before FAIL).
